obi_mem_responder: RTL and testbench

- OBI memory-side responder: the slave end of the core's instruction or data bus, including its integrity signals (reqpar/gntpar/rvalidpar/achk/rchk).
- Single-port word memory with byte-enable writes and a fixed grant-to-response latency.
- Bounded outstanding transactions; integrity-checks incoming requests and generates response parity.
- Used in the cv32e40s benchmark and testbench as the instr and data memory model; also a fault-injection target.

---
 rtl/obi_resp_pkg.sv | 29 ++
 rtl/obi_resp_delay.sv | 45 ++++
 rtl/obi_mem_responder.sv | 129 ++++++++++++
 tb/tb_obi_mem_responder.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_resp_pkg.sv
// Shared response type and integrity helpers for the OBI memory responder.
// Bus checksums use even parity per byte; rchk[4] carries the inverted error flag.
package obi_resp_pkg;

  localparam int MAX_LATENCY = 8;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_resp_t;

  function automatic logic [4:0] calc_rchk(obi_resp_t resp);
    logic [4:0] chk;
    for (int k = 0; k < 4; k++) begin
      chk[k] = ^resp.rdata[8*k +: 8];
    end
    chk[4] = ~resp.err;
    return chk;
  endfunction

  function automatic logic [3:0] calc_achk_lo(logic [31:0] addr);
    logic [3:0] chk;
    for (int k = 0; k < 4; k++) begin
      chk[k] = ^addr[8*k +: 8];
    end
    return chk;
  endfunction

endpackage

// File: rtl/obi_resp_delay.sv
// Fixed-latency response pipeline. Payload only advances behind a valid beat,
// so the last stage keeps the most recent response while no beat is present.
module obi_resp_delay
  import obi_resp_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic      clk_i,
  input  logic      clr_i,
  input  logic      in_valid_i,
  input  obi_resp_t in_resp_i,
  output logic      out_valid_o,
  output obi_resp_t out_resp_o
);

  localparam int STAGES = (LATENCY < 1) ? 1 :
                          (LATENCY > MAX_LATENCY) ? MAX_LATENCY : LATENCY;

  logic [STAGES-1:0] valid_q;
  obi_resp_t         resp_q [STAGES];

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        resp_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid_i;
      if (in_valid_i) begin
        resp_q[0] <= in_resp_i;
      end
      for (int i = 1; i < STAGES; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) begin
          resp_q[i] <= resp_q[i-1];
        end
      end
    end
  end

  assign out_valid_o = valid_q[STAGES-1];
  assign out_resp_o  = resp_q[STAGES-1];

endmodule

// File: rtl/obi_mem_responder.sv
// OBI memory-side responder: word memory with byte-enable writes, fixed
// grant-to-rvalid latency, bounded outstanding count and bus integrity checks.
module obi_mem_responder
  import obi_resp_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DEPTH_WORDS     = 1024,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  reqpar_i,
  output logic                  gnt_o,
  output logic                  gntpar_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [11:0]           achk_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           wdata_i,
  output logic                  rvalid_o,
  output logic                  rvalidpar_o,
  output logic [31:0]           rdata_o,
  output logic [4:0]            rchk_o,
  output logic                  err_o,
  output logic                  integrity_err_o,
  input  logic                  bd_we_i,
  input  logic [ADDR_WIDTH-1:0] bd_addr_i,
  input  logic [31:0]           bd_wdata_i
);

  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [IDX_W-1:0] DEPTH_L = IDX_W'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] MAX_L   = CNT_W'(MAX_OUTSTANDING);

  logic [31:0]      mem_q [DEPTH_WORDS];
  logic [CNT_W-1:0] outst_q, outst_d;
  logic             alarm_q, alarm_d;
  logic             accept, rvalid;
  logic [IDX_W-1:0] idx, bd_idx;
  logic             in_range, bd_in_range;
  logic [31:0]      addr32;
  obi_resp_t        acc_resp, out_resp;
  logic             lsb_unused;

  assign idx         = addr_i[ADDR_WIDTH-1:2];
  assign bd_idx      = bd_addr_i[ADDR_WIDTH-1:2];
  assign in_range    = idx < DEPTH_L;
  assign bd_in_range = bd_idx < DEPTH_L;
  assign addr32      = 32'(addr_i);
  assign lsb_unused  = ^{bd_addr_i[1:0], achk_i[11:4]};

  assign gnt_o    = req_i & ~rst_i & ~bd_we_i & (outst_q < MAX_L);
  assign gntpar_o = ~gnt_o;
  assign accept   = req_i & gnt_o;

  // Backdoor and bus writes never coincide because the backdoor strobe blocks grant.
  always_ff @(posedge clk_i) begin
    if (bd_we_i && bd_in_range) begin
      mem_q[bd_idx[MEM_AW-1:0]] <= bd_wdata_i;
    end else if (accept && we_i && in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) begin
          mem_q[idx[MEM_AW-1:0]][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  always_comb begin
    acc_resp = '0;
    if (!in_range) begin
      acc_resp.err = 1'b1;
    end else if (!we_i) begin
      acc_resp.rdata = mem_q[idx[MEM_AW-1:0]];
    end
  end

  always_comb begin
    outst_d = outst_q;
    case ({accept, rvalid})
      2'b10:   outst_d = outst_q + CNT_W'(1);
      2'b01:   outst_d = outst_q - CNT_W'(1);
      default: outst_d = outst_q;
    endcase
  end

  always_comb begin
    alarm_d = alarm_q;
    if (reqpar_i == req_i) begin
      alarm_d = 1'b1;
    end
    if (accept && (achk_i[3:0] != calc_achk_lo(addr32))) begin
      alarm_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outst_q <= '0;
      alarm_q <= 1'b0;
    end else begin
      outst_q <= outst_d;
      alarm_q <= alarm_d;
    end
  end

  obi_resp_delay #(
    .LATENCY (LATENCY)
  ) u_delay (
    .clk_i       (clk_i),
    .clr_i       (rst_i),
    .in_valid_i  (accept),
    .in_resp_i   (acc_resp),
    .out_valid_o (rvalid),
    .out_resp_o  (out_resp)
  );

  assign rvalid_o        = rvalid;
  assign rvalidpar_o     = ~rvalid;
  assign rdata_o         = out_resp.rdata;
  assign err_o           = out_resp.err;
  assign rchk_o          = calc_rchk(out_resp);
  assign integrity_err_o = alarm_q;

endmodule

// File: tb/tb_obi_mem_responder.sv
// Bench for obi_mem_responder: two instances (latency 1 and 3) share stimulus;
// a per-instance timeline model is compared every cycle, plus literal spot checks.
module tb_obi_mem_responder;

  localparam int DEPTH = 1024;
  localparam int MAXO  = 2;
  localparam int LAT0  = 1;
  localparam int LAT1  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, reqpar = 1'b1, we = 1'b0, bd_we = 1'b0;
  logic [31:0] addr = '0, wdata = '0, bd_addr = '0, bd_wdata = '0;
  logic [11:0] achk = '0;
  logic [3:0]  be = '0;

  logic [1:0]  gnt_w, gntpar_w, rvalid_w, rvalidpar_w, err_w, ierr_w;
  logic [31:0] rdata_w [2];
  logic [4:0]  rchk_w [2];

  always #5 clk = ~clk;

  obi_mem_responder #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT0), .MAX_OUTSTANDING(MAXO)) u_dut_l1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .reqpar_i(reqpar), .gnt_o(gnt_w[0]), .gntpar_o(gntpar_w[0]),
    .addr_i(addr), .achk_i(achk), .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid_w[0]),
    .rvalidpar_o(rvalidpar_w[0]), .rdata_o(rdata_w[0]), .rchk_o(rchk_w[0]), .err_o(err_w[0]),
    .integrity_err_o(ierr_w[0]), .bd_we_i(bd_we), .bd_addr_i(bd_addr), .bd_wdata_i(bd_wdata));

  obi_mem_responder #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT1), .MAX_OUTSTANDING(MAXO)) u_dut_l3 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .reqpar_i(reqpar), .gnt_o(gnt_w[1]), .gntpar_o(gntpar_w[1]),
    .addr_i(addr), .achk_i(achk), .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid_w[1]),
    .rvalidpar_o(rvalidpar_w[1]), .rdata_o(rdata_w[1]), .rchk_o(rchk_w[1]), .err_o(err_w[1]),
    .integrity_err_o(ierr_w[1]), .bd_we_i(bd_we), .bd_addr_i(bd_addr), .bd_wdata_i(bd_wdata));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic logic [4:0] exp_rchk(input logic [31:0] d, input logic e);
    logic [4:0] r;
    for (int k = 0; k < 4; k++) r[k] = (($countones(d[8*k +: 8]) % 2) == 1);
    r[4] = !e;
    return r;
  endfunction

  function automatic logic [3:0] good_achk(input logic [31:0] a);
    logic [3:0] c;
    for (int k = 0; k < 4; k++) c[k] = ^a[8*k +: 8];
    return c;
  endfunction

  // Model: response timeline slots indexed by absolute cycle, plus memory image.
  logic        sv [2][16];
  logic [31:0] sd [2][16];
  logic        se [2][16];
  logic [31:0] mem_m [2][DEPTH];
  int          outs_m [2];
  logic [31:0] last_d [2];
  logic        last_e [2];
  logic        alarm_m [2];

  always @(negedge clk) begin : cmp
    int lat, s, wi, slot;
    logic rv, eg, acc, e;
    logic [31:0] d;
    for (int i = 0; i < 2; i++) begin
      lat = (i == 0) ? LAT0 : LAT1;
      s   = cyc % 16;
      rv  = sv[i][s];
      if (rv === 1'b1) begin
        last_d[i] = sd[i][s];
        last_e[i] = se[i][s];
      end
      eg = req && !rst && !bd_we && (outs_m[i] < MAXO);
      if (chk_en) begin
        chk($sformatf("rvalid%0d", i), rvalid_w[i], rv);
        chk($sformatf("rvalidpar%0d", i), rvalidpar_w[i], !rv);
        chk($sformatf("rdata%0d", i), rdata_w[i], last_d[i]);
        chk($sformatf("err%0d", i), err_w[i], last_e[i]);
        chk($sformatf("rchk%0d", i), rchk_w[i], exp_rchk(last_d[i], last_e[i]));
        chk($sformatf("ierr%0d", i), ierr_w[i], alarm_m[i]);
        chk($sformatf("gnt%0d", i), gnt_w[i], eg);
        chk($sformatf("gntpar%0d", i), gntpar_w[i], !eg);
      end
      acc = req && eg;
      if (bd_we && (int'(bd_addr[31:2]) < DEPTH)) mem_m[i][int'(bd_addr[31:2])] = bd_wdata;
      if (rst) begin
        for (int j = 0; j < 16; j++) sv[i][j] = 1'b0;
        outs_m[i]  = 0;
        last_d[i]  = '0;
        last_e[i]  = 1'b0;
        alarm_m[i] = 1'b0;
      end else begin
        sv[i][s] = 1'b0;
        if (reqpar == req) alarm_m[i] = 1'b1;
        if (acc) begin
          for (int k = 0; k < 4; k++)
            if (achk[k] != ^addr[8*k +: 8]) alarm_m[i] = 1'b1;
          wi = int'(addr[31:2]);
          e  = (wi >= DEPTH);
          d  = '0;
          if (!e) begin
            if (we) begin
              for (int k = 0; k < 4; k++)
                if (be[k]) mem_m[i][wi][8*k +: 8] = wdata[8*k +: 8];
            end else begin
              d = mem_m[i][wi];
            end
          end
          slot = (cyc + lat) % 16;
          sv[i][slot] = 1'b1;
          sd[i][slot] = d;
          se[i][slot] = e;
        end
        outs_m[i] = outs_m[i] + (acc ? 1 : 0) - ((rv === 1'b1) ? 1 : 0);
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic set_idle();
    req = 1'b0; reqpar = 1'b1; we = 1'b0; be = '0; wdata = '0; addr = '0; achk = '0; bd_we = 1'b0;
  endtask

  task automatic set_req(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    req = 1'b1; reqpar = 1'b0; we = w; addr = a; be = b; wdata = d; achk = {8'h00, good_achk(a)};
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    set_req(w, a, b, d);
    tick();
    set_idle();
  endtask

  task automatic bd_write(input logic [31:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_wdata = d;
    tick();
    bd_we = 1'b0;
  endtask

  logic [5:0] gv0, gv1;
  logic [1:0] rv_seen;

  initial begin
    set_idle();
    rst = 1'b1;
    idle(3);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_gntpar", gntpar_w[0], 1'b1);
    chk("rst_rvalidpar", rvalidpar_w[0], 1'b1);
    chk("rst_rchk", rchk_w[0], 5'b10000);
    chk("rst_rdata", rdata_w[1], 32'h0);
    chk("rst_ierr", ierr_w, 2'b00);
    tick();
    rst = 1'b0;
    idle(2);

    bd_write(32'h80, 32'hA5A5_0F0F);
    bd_write(32'h100, 32'h0);
    bd_write(32'h0, 32'h1111_2222);
    for (int k = 1; k < 8; k++) bd_write(32'h80 + 32'(4 * k), 32'h1000_0000 + 32'(k));
    idle(2);

    // preloaded read
    set_req(1'b0, 32'h80, 4'hF, 32'h0);
    @(negedge clk);
    chk("t1_gnt", gnt_w, 2'b11);
    tick();
    set_idle();
    @(negedge clk);
    chk("t1_rvalid", rvalid_w[0], 1'b1);
    chk("t1_rdata", rdata_w[0], 32'hA5A5_0F0F);
    chk("t1_err", err_w[0], 1'b0);
    chk("t1_rchk", rchk_w[0], 5'b10000);
    idle(2);
    @(negedge clk);
    chk("t1_l3_rdata", rdata_w[1], 32'hA5A5_0F0F);
    idle(3);

    // byte-enable write then read-after-write
    issue(1'b1, 32'h100, 4'b0101, 32'hDEAD_BEEF);
    issue(1'b0, 32'h100, 4'hF, 32'h0);
    @(negedge clk);
    chk("t2_rdata", rdata_w[0], 32'h00AD_00EF);
    chk("t2_rchk", rchk_w[0], 5'b10101);
    idle(2);
    @(negedge clk);
    chk("t2_l3_rdata", rdata_w[1], 32'h00AD_00EF);
    idle(3);

    // out of range
    issue(1'b0, 32'h1000, 4'hF, 32'h0);
    @(negedge clk);
    chk("t3_err", err_w[0], 1'b1);
    chk("t3_rdata", rdata_w[0], 32'h0);
    chk("t3_rchk", rchk_w[0], 5'b00000);
    issue(1'b1, 32'h1000, 4'hF, 32'hFFFF_FFFF);
    idle(4);
    issue(1'b0, 32'h0, 4'hF, 32'h0);
    @(negedge clk);
    chk("t3_word0", rdata_w[0], 32'h1111_2222);
    idle(4);

    // outstanding limit with req held high
    for (int k = 0; k < 6; k++) begin
      set_req(1'b0, 32'h84, 4'hF, 32'h0);
      @(negedge clk);
      gv0[k] = gnt_w[0];
      gv1[k] = gnt_w[1];
      tick();
    end
    set_idle();
    idle(6);
    chk("t4_grants_l1", gv0, 6'b111111);
    chk("t4_grants_l3", gv1, 6'b110011);

    // in-order back-to-back responses
    issue(1'b0, 32'h84, 4'hF, 32'h0);
    issue(1'b0, 32'h88, 4'hF, 32'h0);
    issue(1'b0, 32'h8C, 4'hF, 32'h0);
    @(negedge clk);
    chk("t4_order", rdata_w[0], 32'h1000_0003);
    idle(6);

    // request parity alarm, sticky until reset
    set_req(1'b0, 32'h80, 4'hF, 32'h0);
    reqpar = 1'b1;
    tick();
    set_idle();
    @(negedge clk);
    chk("t5_reqpar_alarm", ierr_w, 2'b11);
    idle(4);
    @(negedge clk);
    chk("t5_sticky", ierr_w, 2'b11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_cleared", ierr_w, 2'b00);
    set_req(1'b0, 32'h80, 4'hF, 32'h0);
    achk = achk ^ 12'h004;
    tick();
    set_idle();
    @(negedge clk);
    chk("t5_achk_alarm", ierr_w, 2'b11);
    idle(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(2);

    // backdoor blocks grant
    set_req(1'b0, 32'h80, 4'hF, 32'h0);
    bd_we = 1'b1; bd_addr = 32'h200; bd_wdata = 32'h0000_0055;
    @(negedge clk);
    chk("t7_bd_block", gnt_w, 2'b00);
    tick();
    set_idle();
    issue(1'b0, 32'h200, 4'hF, 32'h0);
    @(negedge clk);
    chk("t7_bd_data", rdata_w[0], 32'h0000_0055);
    idle(4);

    // reset with reads in flight
    set_req(1'b0, 32'h84, 4'hF, 32'h0);
    tick();
    set_req(1'b0, 32'h88, 4'hF, 32'h0);
    tick();
    set_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rv_seen = 2'b00;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      rv_seen = rv_seen | rvalid_w;
      tick();
    end
    chk("t6_no_rvalid", rv_seen, 2'b00);
    set_req(1'b0, 32'h80, 4'hF, 32'h0);
    @(negedge clk);
    chk("t6_gnt_after", gnt_w, 2'b11);
    tick();
    set_idle();
    idle(5);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
